instr_mem_responder: RTL and testbench

Responder end of the instruction-fetch request/grant protocol. It accepts one fetch request at a time from the fetch unit and returns the 32-bit instruction word a fixed number of cycles later. It models a DRAM-like instruction memory with programmable latency, a flush/abort path, range and alignment checking, and a program-load write port for boot or bench preload. It sits between the fetch logic of IF and the instruction array. It replaces the zero-wait instruction memory when latency modelling is needed.

---
 rtl/instr_mem_responder.sv | 121 ++++++++++++
 tb/tb_instr_mem_responder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_responder.sv
// Instruction-fetch responder: one outstanding request, fixed programmable latency,
// flush/abort, range/alignment error responses and a program-load write port.
module instr_mem_responder #(
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned LATENCY  = 2,
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_en,
  input  logic        flush_ip,
  input  logic        instr_req_ip,
  input  logic [31:0] instr_addr_ip,
  output logic        instr_gnt_op,
  output logic        instr_valid_op,
  output logic [31:0] instr_data_op,
  output logic [31:0] instr_addr_op,
  output logic        instr_err_op,
  output logic        busy_op,
  input  logic        load_en_ip,
  input  logic [31:0] load_addr_ip,
  input  logic [31:0] load_data_ip
);

  localparam int unsigned IDX_W      = $clog2(DEPTH);
  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH * 4);
  localparam logic [3:0]  CNT_INIT   = 4'(LATENCY - 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic        respond;

  logic [31:0] mem [DEPTH];
  logic [31:0] pend_data_q;
  logic [31:0] pend_addr_q;
  logic        pend_err_q;

  logic        req_err;
  logic        load_ok;
  logic [IDX_W-1:0] req_idx;
  logic [IDX_W-1:0] load_idx;

  // Full 32-bit compares so high addresses never alias into the array.
  assign req_err  = (instr_addr_ip[1:0] != 2'b00) | (instr_addr_ip >= ADDR_LIMIT);
  assign load_ok  = load_en_ip & (load_addr_ip[1:0] == 2'b00) & (load_addr_ip < ADDR_LIMIT);
  assign req_idx  = instr_addr_ip[IDX_W+1:2];
  assign load_idx = load_addr_ip[IDX_W+1:2];

  assign instr_gnt_op = (state_q == IDLE) & mem_en & ~flush_ip & ~load_en_ip & instr_req_ip;
  assign busy_op      = (state_q == WAIT);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    count_d = count_q;
    respond = 1'b0;
    case (state_q)
      IDLE: begin
        if (instr_gnt_op) begin
          state_d = WAIT;
          count_d = CNT_INIT;
        end
      end
      WAIT: begin
        if (flush_ip) begin
          state_d = IDLE;
          count_d = 4'd0;
        end else if (count_q == 4'd0) begin
          respond = 1'b1;
          state_d = IDLE;
        end else begin
          count_d = count_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = 4'd0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      count_q        <= 4'd0;
      pend_addr_q    <= 32'd0;
      pend_err_q     <= 1'b0;
      instr_valid_op <= 1'b0;
      instr_data_op  <= 32'd0;
      instr_addr_op  <= 32'd0;
      instr_err_op   <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      instr_valid_op <= respond;
      if (instr_gnt_op) begin
        pend_addr_q <= instr_addr_ip;
        pend_err_q  <= req_err;
      end
      if (respond) begin
        instr_data_op <= pend_err_q ? NOP_WORD : pend_data_q;
        instr_addr_op <= pend_addr_q;
        instr_err_op  <= pend_err_q;
      end
    end
  end

  // NOTE: the array and its read register have no reset so they map onto plain RAM.
  always_ff @(posedge clock) begin
    if (load_ok) begin
      mem[load_idx] <= load_data_ip;
    end
    if (instr_gnt_op) begin
      pend_data_q <= mem[req_idx];
    end
  end

endmodule

// File: tb/tb_instr_mem_responder.sv
// Randomized and directed bench for instr_mem_responder, checked against a
// due-time based transaction model of the fetch memory.
module tb_instr_mem_responder;

  localparam int unsigned DEPTH    = 1024;
  localparam int unsigned LATENCY  = 2;
  localparam logic [31:0] NOP_WORD = 32'h00000013;

  logic        clock;
  logic        reset;
  logic        mem_en;
  logic        flush_ip;
  logic        instr_req_ip;
  logic [31:0] instr_addr_ip;
  logic        instr_gnt_op;
  logic        instr_valid_op;
  logic [31:0] instr_data_op;
  logic [31:0] instr_addr_op;
  logic        instr_err_op;
  logic        busy_op;
  logic        load_en_ip;
  logic [31:0] load_addr_ip;
  logic [31:0] load_data_ip;

  instr_mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY), .NOP_WORD(NOP_WORD)) dut (
    .clock          (clock),
    .reset          (reset),
    .mem_en         (mem_en),
    .flush_ip       (flush_ip),
    .instr_req_ip   (instr_req_ip),
    .instr_addr_ip  (instr_addr_ip),
    .instr_gnt_op   (instr_gnt_op),
    .instr_valid_op (instr_valid_op),
    .instr_data_op  (instr_data_op),
    .instr_addr_op  (instr_addr_op),
    .instr_err_op   (instr_err_op),
    .busy_op        (busy_op),
    .load_en_ip     (load_en_ip),
    .load_addr_ip   (load_addr_ip),
    .load_data_ip   (load_data_ip)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: word array plus one pending transaction with an absolute due edge.
  logic [31:0] model_mem [DEPTH];
  longint      edge_n = 0;
  bit          pend_valid = 0;
  longint      pend_due = 0;
  logic [31:0] pend_data = 0, pend_addr = 0;
  bit          pend_err = 0;
  bit          exp_gnt = 0;
  bit          exp_valid = 0;
  logic [31:0] exp_data = 0, exp_addr = 0;
  bit          exp_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic bit addr_bad(input logic [31:0] a);
    return (a % 4 != 0) || (a >= DEPTH * 4);
  endfunction

  task automatic model_edge();
    exp_valid = 0;
    if (pend_valid) begin
      if (flush_ip) begin
        pend_valid = 0;
      end else if (edge_n == pend_due) begin
        exp_valid  = 1;
        exp_data   = pend_err ? NOP_WORD : pend_data;
        exp_addr   = pend_addr;
        exp_err    = pend_err;
        pend_valid = 0;
      end
    end
    if (exp_gnt) begin
      pend_valid = 1;
      pend_due   = edge_n + LATENCY;
      pend_addr  = instr_addr_ip;
      pend_err   = addr_bad(instr_addr_ip);
      pend_data  = pend_err ? 32'd0 : model_mem[instr_addr_ip / 4];
    end
    if (load_en_ip && !addr_bad(load_addr_ip))
      model_mem[load_addr_ip / 4] = load_data_ip;
  endtask

  // Called just after a rising edge with inputs already set; checks at the falling edge.
  task automatic cycle();
    @(negedge clock);
    exp_gnt = !pend_valid && mem_en && !flush_ip && !load_en_ip && instr_req_ip;
    check("gnt",   instr_gnt_op,   exp_gnt);
    check("busy",  busy_op,        pend_valid);
    check("valid", instr_valid_op, exp_valid);
    check("data",  instr_data_op,  exp_data);
    check("raddr", instr_addr_op,  exp_addr);
    check("err",   instr_err_op,   exp_err);
    @(posedge clock);
    edge_n++;
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    instr_req_ip = 0; flush_ip = 0; load_en_ip = 0; mem_en = 1;
  endtask

  task automatic load_word(input logic [31:0] a, input logic [31:0] d);
    load_en_ip = 1; load_addr_ip = a; load_data_ip = d;
    cycle();
    load_en_ip = 0;
  endtask

  task automatic fetch_expect(input string tag, input logic [31:0] a,
                              input logic [31:0] want_data, input logic want_err);
    instr_req_ip = 1; instr_addr_ip = a;
    #1 check({tag, "_gnt"}, instr_gnt_op, 1'b1);
    cycle();
    instr_req_ip = 0;
    repeat (LATENCY) cycle();
    check({tag, "_valid"}, instr_valid_op, 1'b1);
    check({tag, "_data"},  instr_data_op,  want_data);
    check({tag, "_addr"},  instr_addr_op,  a);
    check({tag, "_err"},   instr_err_op,   want_err);
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned pick = $urandom_range(0, 9);
    if (pick < 7)       return {20'd0, 10'($urandom_range(0, DEPTH - 1)), 2'b00};
    else if (pick == 7) return {20'd0, 10'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(1, 3))};
    else if (pick == 8) return 32'(DEPTH * 4) + {$urandom_range(0, 255), 2'b00};
    else                return $urandom;
  endfunction

  logic [31:0] old_word;

  initial begin
    reset = 1; idle_inputs();
    instr_addr_ip = 0; load_addr_ip = 0; load_data_ip = 0;
    repeat (2) @(posedge clock);
    #1 reset = 0;

    // Reset values are checked by the first cycle; then preload the whole array.
    for (int i = 0; i < DEPTH; i++) load_word(32'(i * 4), $urandom);

    load_word(32'h0, 32'h00500093);
    load_word(32'h4, 32'h00100113);

    // Basic fetch, then a request held across the busy window is granted in the valid cycle.
    instr_req_ip = 1; instr_addr_ip = 32'h0;
    cycle();
    instr_addr_ip = 32'h4;
    repeat (LATENCY) cycle();
    check("tp1_valid", instr_valid_op, 1'b1);
    check("tp1_data",  instr_data_op,  32'h00500093);
    check("b2b_gnt",   instr_gnt_op,   1'b1);
    cycle();
    instr_req_ip = 0;
    repeat (LATENCY) cycle();
    check("tp2_data",  instr_data_op,  32'h00100113);
    cycle();
    check("valid_drop", instr_valid_op, 1'b0);
    check("data_hold",  instr_data_op,  32'h00100113);

    fetch_expect("misalign", 32'h6,    NOP_WORD, 1'b1);
    fetch_expect("oor",      32'h1000, NOP_WORD, 1'b1);

    // Flush one cycle after accept, then flush on the response edge itself.
    instr_req_ip = 1; instr_addr_ip = 32'h0;
    cycle();
    instr_req_ip = 0; flush_ip = 1;
    cycle();
    flush_ip = 0;
    check("flush_busy",  busy_op,        1'b0);
    check("flush_valid", instr_valid_op, 1'b0);
    fetch_expect("post_flush", 32'h4, 32'h00100113, 1'b0);
    instr_req_ip = 1; instr_addr_ip = 32'h0;
    cycle();
    instr_req_ip = 0;
    repeat (LATENCY - 1) cycle();
    flush_ip = 1;
    cycle();
    flush_ip = 0;
    check("late_flush_valid", instr_valid_op, 1'b0);

    // A visible valid is not retracted by a flush in the same cycle.
    fetch_expect("pre_retract", 32'h0, 32'h00500093, 1'b0);
    flush_ip = 1;
    #1 check("flush_keeps_valid", instr_valid_op, 1'b1);
    cycle();
    flush_ip = 0;

    // Load beats request; a load during WAIT does not alter the in-flight word.
    instr_req_ip = 1; instr_addr_ip = 32'h0;
    load_en_ip = 1; load_addr_ip = 32'h100; load_data_ip = $urandom;
    #1 check("load_blocks_gnt", instr_gnt_op, 1'b0);
    cycle();
    load_en_ip = 0; instr_req_ip = 0;
    old_word = model_mem[2];
    instr_req_ip = 1; instr_addr_ip = 32'h8;
    cycle();
    instr_req_ip = 0;
    load_word(32'h8, 32'hDEADBEEF);
    repeat (LATENCY - 1) cycle();
    check("inflight_old", instr_data_op, old_word);
    fetch_expect("reload", 32'h8, 32'hDEADBEEF, 1'b0);

    // mem_en low blocks grants but not an in-flight response.
    mem_en = 0; instr_req_ip = 1; instr_addr_ip = 32'h4;
    for (int i = 0; i < 6; i++) begin
      #1 check("mem_en_block", instr_gnt_op, 1'b0);
      cycle();
    end
    mem_en = 1;
    cycle();
    mem_en = 0; instr_req_ip = 0;
    repeat (LATENCY) cycle();
    check("mem_en_inflight", instr_data_op, 32'h00100113);
    mem_en = 1;

    // Asynchronous reset in the middle of WAIT.
    instr_req_ip = 1; instr_addr_ip = 32'h0;
    cycle();
    instr_req_ip = 0;
    #2 reset = 1;
    #1;
    check("rst_busy",  busy_op,        1'b0);
    check("rst_valid", instr_valid_op, 1'b0);
    check("rst_data",  instr_data_op,  32'd0);
    check("rst_addr",  instr_addr_op,  32'd0);
    check("rst_err",   instr_err_op,   1'b0);
    pend_valid = 0; exp_valid = 0; exp_data = 0; exp_addr = 0; exp_err = 0;
    @(posedge clock);
    edge_n++;
    #1 reset = 0;
    repeat (4) cycle();
    fetch_expect("post_reset", 32'h0, 32'h00500093, 1'b0);

    // Randomized traffic checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      mem_en       = ($urandom_range(0, 9) != 0);
      flush_ip     = ($urandom_range(0, 19) == 0);
      instr_req_ip = ($urandom_range(0, 3) != 0);
      instr_addr_ip = rand_addr();
      load_en_ip   = ($urandom_range(0, 9) == 0);
      load_addr_ip = rand_addr();
      load_data_ip = $urandom;
      cycle();
    end
    idle_inputs();
    repeat (LATENCY + 2) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
